// File: rtl/pattern_sequencer_if.sv
// pattern_sequencer_if: command/response bundle between the game fsm and the pattern sequencer
interface pattern_sequencer_if #(
    parameter int MAX_ROUNDS = 32
) ();
    localparam int W = $clog2(MAX_ROUNDS + 1);
    logic         clear;
    logic         add_clr;
    logic         play_start;
    logic         speed_up;
    logic         check_valid;
    logic [3:0]   player_input;
    logic         pulse;
    logic [3:0]   led;
    logic         play_busy;
    logic         play_done;
    logic         result_valid;
    logic         result;
    logic         round_complete;
    logic [W-1:0] seq_len;
    logic         full;
    modport master (
        output clear, add_clr, play_start, speed_up, check_valid, player_input,
        input  pulse, led, play_busy, play_done, result_valid, result, round_complete, seq_len, full
    );
    modport slave (
        input  clear, add_clr, play_start, speed_up, check_valid, player_input,
        output pulse, led, play_busy, play_done, result_valid, result, round_complete, seq_len, full
    );
endinterface

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: stores the random colour sequence, generates the tempo pulse, plays back and checks entries
module pattern_sequencer #(
    parameter int          MAX_ROUNDS = 32,
    parameter int          BASE_TICKS = 25_000_000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic clk,
    input logic reset,
    pattern_sequencer_if.slave bus
);
    localparam int W  = $clog2(MAX_ROUNDS + 1);
    localparam int IW = MAX_ROUNDS > 1 ? $clog2(MAX_ROUNDS) : 1;
    localparam int CW = BASE_TICKS > 1 ? $clog2(BASE_TICKS) : 1;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {IDLE, WAIT_ON, PLAY_ON, PLAY_OFF} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    speed_q, speed_d;
    logic [15:0]   lfsr_q;
    logic [1:0]    mem_q [MAX_ROUNDS];
    logic [W-1:0]  seq_len_q, seq_len_d;
    logic [W-1:0]  idx_q, idx_d;
    logic [W-1:0]  chk_q, chk_d;
    logic [W-1:0]  nxt;
    logic [3:0]    led_q, led_d;
    logic [3:0]    led_on;
    logic [3:0]    chk_clr;
    logic          play_done_q, play_done_d;
    logic          result_q, result_d;
    logic          result_valid_q, result_valid_d;
    logic          round_complete_q, round_complete_d;
    logic          pulse, full, wr_en, match;

    assign pulse   = cnt_q == '0;
    assign full    = seq_len_q == W'(MAX_ROUNDS);
    assign wr_en   = state_q == IDLE && !bus.clear && !bus.play_start && bus.add_clr && !full;
    assign chk_clr = 4'b0001 << mem_q[chk_q[IW-1:0]];
    assign match   = seq_len_q != '0 && bus.player_input == chk_clr;
    // Colour lit on entering PLAY_ON: the first entry from WAIT_ON, the following one from PLAY_OFF
    assign nxt     = idx_q + W'(state_q == PLAY_OFF);
    assign led_on  = 4'b0001 << mem_q[nxt[IW-1:0]];

    // Next-state: tempo reload, speed level, playback walk and entry checking
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        chk_d            = chk_q;
        seq_len_d        = seq_len_q;
        led_d            = led_q;
        result_d         = result_q;
        play_done_d      = 1'b0;
        result_valid_d   = 1'b0;
        round_complete_d = 1'b0;
        cnt_d            = pulse ? CW'((BASE_TICKS >> speed_q) - 1) : cnt_q - CW'(1);
        speed_d          = bus.clear ? 2'd0 : (bus.speed_up && speed_q != 2'd3) ? speed_q + 2'd1 : speed_q;
        if (bus.clear) begin
            state_d   = IDLE;
            idx_d     = '0;
            chk_d     = '0;
            seq_len_d = '0;
            led_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.play_start) begin
                        state_d     = seq_len_q != '0 ? WAIT_ON : IDLE;
                        idx_d       = '0;
                        play_done_d = seq_len_q == '0;
                    end else if (bus.add_clr) begin
                        seq_len_d = full ? seq_len_q : seq_len_q + ONE;
                    end else if (bus.check_valid) begin
                        result_valid_d   = 1'b1;
                        result_d         = match;
                        round_complete_d = match && chk_q == seq_len_q - ONE;
                        chk_d            = (match && chk_q != seq_len_q - ONE) ? chk_q + ONE : '0;
                    end
                end
                WAIT_ON: begin
                    state_d = pulse ? PLAY_ON : WAIT_ON;
                    led_d   = pulse ? led_on : led_q;
                end
                PLAY_ON: begin
                    state_d = pulse ? PLAY_OFF : PLAY_ON;
                    led_d   = pulse ? 4'b0000 : led_q;
                end
                PLAY_OFF: begin
                    if (pulse && idx_q == seq_len_q - ONE) begin
                        state_d     = IDLE;
                        play_done_d = 1'b1;
                    end else if (pulse) begin
                        state_d = PLAY_ON;
                        idx_d   = nxt;
                        led_d   = led_on;
                    end
                end
            endcase
        end
    end

    // Registers; the LFSR free-runs and only reset reloads it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            cnt_q            <= CW'(BASE_TICKS - 1);
            speed_q          <= 2'd0;
            lfsr_q           <= LFSR_SEED;
            seq_len_q        <= '0;
            idx_q            <= '0;
            chk_q            <= '0;
            led_q            <= '0;
            play_done_q      <= 1'b0;
            result_q         <= 1'b0;
            result_valid_q   <= 1'b0;
            round_complete_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            speed_q          <= speed_d;
            lfsr_q           <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            seq_len_q        <= seq_len_d;
            idx_q            <= idx_d;
            chk_q            <= chk_d;
            led_q            <= led_d;
            play_done_q      <= play_done_d;
            result_q         <= result_d;
            result_valid_q   <= result_valid_d;
            round_complete_q <= round_complete_d;
        end
    end

    // Colour store; entries beyond seq_len are never read, so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[seq_len_q[IW-1:0]] <= lfsr_q[1:0];
    end

    assign bus.pulse          = pulse;
    assign bus.led            = led_q;
    assign bus.play_busy      = state_q != IDLE;
    assign bus.play_done      = play_done_q;
    assign bus.result_valid   = result_valid_q;
    assign bus.result         = result_q;
    assign bus.round_complete = round_complete_q;
    assign bus.seq_len        = seq_len_q;
    assign bus.full           = full;
endmodule
